// File: rtl/uart_rx_pkt_parser_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_parser_pkg
//   Shared definitions for the UART packet parser: FSM state encoding,
//   error cause codes, the default sync marker and a length check helper.
//   No ports; imported by uart_rx_pkt_parser.
// ---------------------------------------------------------------------------
package uart_rx_pkt_parser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_OUTPUT  = 3'd4
  } pktState_e;

  typedef logic [1:0] errCode_t;

  localparam errCode_t ERR_LEN     = 2'd1;
  localparam errCode_t ERR_CSUM    = 2'd2;
  localparam errCode_t ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // A length byte is usable when it is non-zero and fits in the buffer.
  function automatic logic isLenValid(input logic [7:0] lenByte, input int unsigned maxLen);
    return (lenByte != 8'd0) && (32'(lenByte) <= maxLen);
  endfunction

endpackage

// File: rtl/uart_pkt_buffer.sv
// ---------------------------------------------------------------------------
// uart_pkt_buffer
//   Payload storage for the packet parser: DEPTH x 8 register array with one
//   synchronous write port and a combinational read port. No reset; the
//   parser never reads a location it has not written in the current frame.
// Ports:
//   clock_i    : write clock
//   wrEn_i     : write strobe
//   wrAddr_i   : write address
//   wrData_i   : write data
//   rdAddr_i   : read address
//   rdData_o   : read data (combinational)
// ---------------------------------------------------------------------------
module uart_pkt_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock_i,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [7:0]        wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [7:0]        rdData_o
);

  logic [7:0] mem_q [DEPTH];

  // Plain write port; contents are don't-care after reset.
  always_ff @(posedge clock_i) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_parser
//   Framing stage behind the UART byte receiver. Hunts for SYNC_BYTE, reads a
//   length byte, buffers LEN payload bytes, verifies an 8-bit wrap-around
//   checksum (LEN + payload + CSUM == 0) and only then replays the payload as
//   a valid/ready stream. Bad length, bad checksum and inter-byte timeout drop
//   the frame and pulse o_Err with a cause code.
// Ports:
//   i_Clock, i_Rst_L          : clock, async active-low reset
//   i_Rx_DV, i_Rx_Byte        : one-cycle byte strobe and byte from receiver
//   o_Pkt_Valid, i_Pkt_Ready  : output stream handshake
//   o_Pkt_Data, o_Pkt_Last    : payload byte and final-byte marker
//   o_Pkt_Len                 : length of the frame being output
//   o_Err, o_Err_Code         : one-cycle error pulse and its cause
//   o_Overrun                 : one-cycle pulse per byte dropped during output
// ---------------------------------------------------------------------------
module uart_rx_pkt_parser
  import uart_rx_pkt_parser_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 52080
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Pkt_Valid,
  input  logic       i_Pkt_Ready,
  output logic [7:0] o_Pkt_Data,
  output logic       o_Pkt_Last,
  output logic [7:0] o_Pkt_Len,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

  pktState_e        state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [7:0]       len_q, len_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  errCode_t         errCode_q, errCode_d;
  logic             overrun_q, overrun_d;

  logic       syncSeen;
  logic       lenOk;
  logic       tmoExpired;
  logic       wrLast;
  logic       rdAtLast;
  logic       csumOk;
  logic       wrEn;
  logic [7:0] lenLast;
  logic [7:0] accSum;
  logic [7:0] rdData;

  assign lenLast    = len_q - 8'd1;
  assign accSum     = acc_q + i_Rx_Byte;
  assign syncSeen   = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);
  assign lenOk      = isLenValid(i_Rx_Byte, MAX_LEN);
  assign tmoExpired = !i_Rx_DV && (tmo_q == TMO_LAST);
  assign wrLast     = (8'(idx_q) == lenLast);
  assign rdAtLast   = (8'(rd_q) == lenLast);
  assign csumOk     = (accSum == 8'd0);
  assign wrEn       = (state_q == ST_PAYLOAD) && i_Rx_DV;

  uart_pkt_buffer #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (IDX_W)
  ) u_buffer (
    .clock_i  (i_Clock),
    .wrEn_i   (wrEn),
    .wrAddr_i (idx_q),
    .wrData_i (i_Rx_Byte),
    .rdAddr_i (rd_q),
    .rdData_o (rdData)
  );

  // State register; reset drops any partial frame or packet in flight.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A received byte always takes priority over timeout
  // expiry on the same clock, which is why expiry is qualified by !i_Rx_DV.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (syncSeen) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (i_Rx_DV)         state_d = lenOk ? ST_PAYLOAD : ST_IDLE;
        else if (tmoExpired) state_d = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (i_Rx_DV) begin
          if (wrLast) state_d = ST_CHECK;
        end else if (tmoExpired) begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (i_Rx_DV)         state_d = csumOk ? ST_OUTPUT : ST_IDLE;
        else if (tmoExpired) state_d = ST_IDLE;
      end
      ST_OUTPUT: begin
        if (i_Pkt_Ready && rdAtLast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stream outputs decode straight from state so a stalled byte stays put.
  // Data is forced to zero outside OUTPUT because the buffer has no reset.
  always_comb begin
    o_Pkt_Valid = 1'b0;
    o_Pkt_Data  = 8'h00;
    o_Pkt_Last  = 1'b0;
    if (state_q == ST_OUTPUT) begin
      o_Pkt_Valid = 1'b1;
      o_Pkt_Data  = rdData;
      o_Pkt_Last  = rdAtLast;
    end
  end

  assign o_Pkt_Len  = len_q;
  assign o_Err      = err_q;
  assign o_Err_Code = errCode_q;
  assign o_Overrun  = overrun_q;

  // Datapath next values: checksum accumulator, write/read indices, the
  // inter-byte timer and the registered error/overrun pulses. The error code
  // only changes when a new error is raised so it keeps its last cause.
  always_comb begin
    acc_d     = acc_q;
    idx_d     = idx_q;
    rd_d      = rd_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    errCode_d = errCode_q;
    overrun_d = 1'b0;

    if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHECK) begin
      tmo_d = i_Rx_DV ? '0 : tmo_q + TMO_W'(1);
      if (tmoExpired) begin
        err_d     = 1'b1;
        errCode_d = ERR_TIMEOUT;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (syncSeen) begin
          acc_d = 8'h00;
          idx_d = '0;
          tmo_d = '0;
        end
      end
      ST_LEN: begin
        if (i_Rx_DV) begin
          if (lenOk) begin
            len_d = i_Rx_Byte;
            acc_d = i_Rx_Byte;
            idx_d = '0;
          end else begin
            err_d     = 1'b1;
            errCode_d = ERR_LEN;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_Rx_DV) begin
          acc_d = accSum;
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_CHECK: begin
        if (i_Rx_DV) begin
          if (csumOk) begin
            rd_d = '0;
          end else begin
            err_d     = 1'b1;
            errCode_d = ERR_CSUM;
          end
        end
      end
      ST_OUTPUT: begin
        if (i_Rx_DV) overrun_d = 1'b1;
        if (i_Pkt_Ready && !rdAtLast) rd_d = rd_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      acc_q     <= 8'h00;
      idx_q     <= '0;
      rd_q      <= '0;
      len_q     <= 8'h00;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      errCode_q <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      len_q     <= len_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      errCode_q <= errCode_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pkt_parser
//   Directed bench for uart_rx_pkt_parser. Inputs change on the falling edge,
//   outputs are sampled on the falling edge after the rising edge of interest.
//   TIMEOUT_CLKS is shortened so the timeout cases stay quick.
// ---------------------------------------------------------------------------
module tb_uart_rx_pkt_parser;

  localparam int unsigned TB_MAX_LEN = 16;
  localparam int unsigned TB_TMO     = 64;

  logic       clock;
  logic       rstN;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       pktValid;
  logic       pktReady;
  logic [7:0] pktData;
  logic       pktLast;
  logic [7:0] pktLen;
  logic       err;
  logic [1:0] errCode;
  logic       overrun;

  int vectorCount;
  int failCount;

  logic [7:0] txBytes [$];
  logic [7:0] expBytes [$];

  uart_rx_pkt_parser #(
    .MAX_LEN      (TB_MAX_LEN),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TB_TMO)
  ) dut (
    .i_Clock     (clock),
    .i_Rst_L     (rstN),
    .i_Rx_DV     (rxDv),
    .i_Rx_Byte   (rxByte),
    .o_Pkt_Valid (pktValid),
    .i_Pkt_Ready (pktReady),
    .o_Pkt_Data  (pktData),
    .o_Pkt_Last  (pktLast),
    .o_Pkt_Len   (pktLen),
    .o_Err       (err),
    .o_Err_Code  (errCode),
    .o_Overrun   (overrun)
  );

  // 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so a wedged run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge: presents one byte for exactly one rising edge
  // and returns on the next falling edge. Consecutive calls give
  // back-to-back strobes.
  task automatic applyStimulus(input logic [7:0] b);
    rxDv   = 1'b1;
    rxByte = b;
    @(negedge clock);
    rxDv   = 1'b0;
    rxByte = 8'h00;
  endtask

  task automatic applyTxQueue();
    foreach (txBytes[i]) applyStimulus(txBytes[i]);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Consumes the packet in expBytes, checking order, stability under stall,
  // last placement and length. Random ready when randomReady is set.
  task automatic drainPacket(input string tag, input bit randomReady);
    int idx;
    int cycles;
    int n;
    idx    = 0;
    cycles = 0;
    n      = expBytes.size();
    while (idx < n && cycles < 300) begin
      checkOutput({tag, "_valid"}, 32'(pktValid), 32'd1);
      checkOutput({tag, "_data"}, 32'(pktData), 32'(expBytes[idx]));
      checkOutput({tag, "_last"}, 32'(pktLast), 32'(idx == n - 1));
      checkOutput({tag, "_len"}, 32'(pktLen), 32'(n));
      pktReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (pktReady) idx++;
      cycles++;
    end
    checkOutput({tag, "_count"}, 32'(idx), 32'(n));
    if (!randomReady) checkOutput({tag, "_cycles"}, 32'(cycles), 32'(n));
    checkOutput({tag, "_validDrop"}, 32'(pktValid), 32'd0);
    pktReady = 1'b1;
  endtask

  initial begin
    vectorCount = 0;
    failCount   = 0;
    rstN        = 1'b0;
    rxDv        = 1'b0;
    rxByte      = 8'h00;
    pktReady    = 1'b1;

    // Reset values.
    idleCycles(3);
    checkOutput("rst_valid",   32'(pktValid), 32'd0);
    checkOutput("rst_data",    32'(pktData),  32'd0);
    checkOutput("rst_last",    32'(pktLast),  32'd0);
    checkOutput("rst_len",     32'(pktLen),   32'd0);
    checkOutput("rst_err",     32'(err),      32'd0);
    checkOutput("rst_errCode", 32'(errCode),  32'd0);
    checkOutput("rst_overrun", 32'(overrun),  32'd0);
    rstN = 1'b1;
    idleCycles(1);

    // Good frame, back-to-back bytes: 3+1+2+3+F7 = 0x100.
    txBytes = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    applyTxQueue();
    checkOutput("good_err", 32'(err), 32'd0);
    expBytes = '{8'h01, 8'h02, 8'h03};
    drainPacket("good", 1'b0);

    // Sync in the cycle right after the last handshake must be parsed:
    // length 0 then raises a length error.
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    checkOutput("len0_err",  32'(err),     32'd1);
    checkOutput("len0_code", 32'(errCode), 32'd1);
    idleCycles(1);
    checkOutput("len0_pulse", 32'(err), 32'd0);

    // Length 0x11 exceeds MAX_LEN.
    applyStimulus(8'hA5);
    applyStimulus(8'h11);
    checkOutput("len17_err",  32'(err),     32'd1);
    checkOutput("len17_code", 32'(errCode), 32'd1);
    idleCycles(1);

    // Bad checksum: 2+10+20+00 = 0x32.
    txBytes = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    applyTxQueue();
    checkOutput("csum_err",   32'(err),      32'd1);
    checkOutput("csum_code",  32'(errCode),  32'd2);
    checkOutput("csum_valid", 32'(pktValid), 32'd0);
    idleCycles(1);
    checkOutput("csum_pulse", 32'(err),     32'd0);
    checkOutput("csum_hold",  32'(errCode), 32'd2);

    // Single-byte frame: 1+7F+80 = 0x100.
    txBytes = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    applyTxQueue();
    checkOutput("one_err", 32'(err), 32'd0);
    expBytes = '{8'h7F};
    drainPacket("one", 1'b0);

    // Garbage before any sync is ignored silently.
    txBytes = '{8'h00, 8'hFF, 8'h5A};
    foreach (txBytes[i]) begin
      applyStimulus(txBytes[i]);
      checkOutput("garbage_err",   32'(err),      32'd0);
      checkOutput("garbage_valid", 32'(pktValid), 32'd0);
    end

    // Timeout: silence after a payload byte expires after TB_TMO clocks.
    txBytes = '{8'hA5, 8'h04, 8'h11};
    applyTxQueue();
    idleCycles(TB_TMO - 1);
    checkOutput("tmo_early", 32'(err), 32'd0);
    idleCycles(1);
    checkOutput("tmo_err",  32'(err),     32'd1);
    checkOutput("tmo_code", 32'(errCode), 32'd3);
    idleCycles(1);
    checkOutput("tmo_once", 32'(err), 32'd0);
    idleCycles(TB_TMO + 4);
    checkOutput("tmo_idle", 32'(err), 32'd0);

    // A byte on the expiry clock wins: 4+11+22+33+44 = 0xAE, csum 0x52.
    txBytes = '{8'hA5, 8'h04, 8'h11};
    applyTxQueue();
    idleCycles(TB_TMO - 1);
    applyStimulus(8'h22);
    checkOutput("expiry_err", 32'(err), 32'd0);
    txBytes = '{8'h33, 8'h44, 8'h52};
    applyTxQueue();
    checkOutput("expiry_frameErr", 32'(err), 32'd0);
    expBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    drainPacket("expiry", 1'b0);

    // Full-length frame under random backpressure: LEN 0x10, payload 1..16
    // sums to 0x88, so 0x10+0x88 = 0x98 and csum is 0x68.
    txBytes = '{8'hA5, 8'h10};
    expBytes.delete();
    for (int i = 1; i <= 16; i++) begin
      txBytes.push_back(8'(i));
      expBytes.push_back(8'(i));
    end
    txBytes.push_back(8'h68);
    applyTxQueue();
    checkOutput("bp_err", 32'(err), 32'd0);
    drainPacket("bp", 1'b1);

    // Overrun: 2+AA+BB = 0x167, csum 0x99. Sync during output is dropped.
    pktReady = 1'b0;
    txBytes = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h99};
    applyTxQueue();
    checkOutput("ovr_validPre", 32'(pktValid), 32'd1);
    applyStimulus(8'hA5);
    checkOutput("ovr_pulse", 32'(overrun),  32'd1);
    checkOutput("ovr_valid", 32'(pktValid), 32'd1);
    checkOutput("ovr_data",  32'(pktData),  32'hAA);
    idleCycles(1);
    checkOutput("ovr_pulseEnd", 32'(overrun), 32'd0);
    expBytes = '{8'hAA, 8'hBB};
    drainPacket("ovr", 1'b0);
    // Had the dropped sync started a frame, this 00 would be a bad length.
    applyStimulus(8'h00);
    checkOutput("ovr_noFrame", 32'(err), 32'd0);

    // Reset mid-payload clears every output, then a good frame parses.
    txBytes = '{8'hA5, 8'h04, 8'h11, 8'h22};
    applyTxQueue();
    rstN = 1'b0;
    #1;
    checkOutput("midrst_valid",   32'(pktValid), 32'd0);
    checkOutput("midrst_data",    32'(pktData),  32'd0);
    checkOutput("midrst_last",    32'(pktLast),  32'd0);
    checkOutput("midrst_len",     32'(pktLen),   32'd0);
    checkOutput("midrst_err",     32'(err),      32'd0);
    checkOutput("midrst_errCode", 32'(errCode),  32'd0);
    checkOutput("midrst_overrun", 32'(overrun),  32'd0);
    @(negedge clock);
    rstN = 1'b1;
    idleCycles(1);
    txBytes = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    applyTxQueue();
    checkOutput("post_err", 32'(err), 32'd0);
    expBytes = '{8'h7F};
    drainPacket("post", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
